// File: rtl/serdes_tx.sv
// 8b/10b serial transmitter. It sends a K28.5 comma preamble after reset and
// then serialises data_in symbols, filling idle words with K28.5. Bit a of each
// 10-bit code goes out first. The block also contains the combinational 8b/10b
// encoder that it uses.
`timescale 1ns/1ps

// 8b/10b encoder.
// datain = {K, HGFEDCBA}. dataout = {j,h,g,f,i,e,d,c,b,a}.
// A K symbol is first built in its RD- form. If dispin is RD+, the whole
// 10-bit code is then inverted.
module encode (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);

  // 5b/6b code for EDCBA in its RD- form, written as abcdei (a = MSB)
  function automatic logic [5:0] f_6b_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;  5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;  5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;  5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;  5'd19: c = 6'b110010;  5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;  5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;  5'd31: c = 6'b101011;
      default: c = 6'b000000;
    endcase
    return c;
  endfunction

  // 3b/4b primary code for HGF in its RD- form, written as fghj (f = MSB)
  function automatic logic [3:0] f_4b_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;  3'd4: c = 4'b1101;  3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;  3'd7: c = 4'b1110;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Count the ones in a 10-bit vector
  function automatic logic [3:0] f_ones(input logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k;
  logic       w_rd_in;
  logic       w_rd6;
  logic       w_alt7;
  logic [5:0] w_c6;
  logic [3:0] w_c4;
  logic [3:0] w_n6;
  logic [3:0] w_n4;
  logic [3:0] w_n10;
  logic [9:0] w_code;

  // Build the 6b and 4b sub-blocks and the running disparity after the code
  always_comb begin
    w_x     = datain[4:0];
    w_y     = datain[7:5];
    w_k     = datain[8];
    w_rd_in = w_k ? 1'b0 : dispin;
    if (w_k && (w_x == 5'd28)) begin
      w_c6 = 6'b001111;
    end else begin
      w_c6 = f_6b_neg(w_x);
    end
    w_n6 = f_ones({4'b0000, w_c6});
    // D.07 is balanced but still takes its alternate form under RD+.
    if (w_rd_in && ((w_n6 != 4'd3) || (w_x == 5'd7))) begin
      w_c6 = ~w_c6;
    end else begin
      w_c6 = w_c6;
    end
    if (w_n6 == 4'd3) begin
      w_rd6 = w_rd_in;
    end else begin
      w_rd6 = (f_ones({4'b0000, w_c6}) > 4'd3);
    end
    // The alternate x.7 code (A7) avoids a run of five equal bits.
    w_alt7 = (w_y == 3'd7) &&
             (w_k ||
              (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
              ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));
    if (w_alt7) begin
      w_c4 = 4'b0111;
    end else begin
      w_c4 = f_4b_neg(w_y);
    end
    w_n4 = f_ones({6'b000000, w_c4});
    if (w_rd6 && ((w_n4 != 4'd2) || (w_y == 3'd3))) begin
      w_c4 = ~w_c4;
    end else begin
      w_c4 = w_c4;
    end
    w_code = {w_c4[0], w_c4[1], w_c4[2], w_c4[3],
              w_c6[0], w_c6[1], w_c6[2], w_c6[3], w_c6[4], w_c6[5]};
    if (w_k && dispin) begin
      w_code = ~w_code;
    end else begin
      w_code = w_code;
    end
    w_n10   = f_ones(w_code);
    dataout = w_code;
    if (w_n10 > 4'd5) begin
      dispout = 1'b1;
    end else if (w_n10 < 4'd5) begin
      dispout = 1'b0;
    end else begin
      dispout = dispin;
    end
  end

endmodule

module serdes_tx #(
  parameter int SYNC_COMMAS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       sync_done,
  output logic       disp_out
);

  localparam logic [8:0] LP_K28_5 = 9'h1BC;
  localparam logic [3:0] LP_SYNC  = 4'(SYNC_COMMAS);

  typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_sync_cnt;
  logic [9:0] r_shift;
  logic       r_tx;
  logic       r_rd;

  logic       w_boundary;
  logic [8:0] w_sym;
  logic [9:0] w_enc_code;
  logic       w_enc_disp;

  assign w_boundary = enable && (r_cnt == 4'd9);
  assign w_sym      = ((r_state == ST_RUN) && data_valid) ? data_in : LP_K28_5;
  assign data_ready = w_boundary && (r_state == ST_RUN);
  assign tx_out     = r_tx;
  assign sync_done  = (r_state == ST_RUN);
  assign disp_out   = r_rd;

  encode u_encode (
    .datain  (w_sym),
    .dispin  (r_rd),
    .dataout (w_enc_code),
    .dispout (w_enc_disp)
  );

  // Bit serialiser and SYNC/RUN control: load a new word at the boundary, otherwise shift out the next bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_SYNC;
      r_cnt      <= 4'd9;
      r_sync_cnt <= 4'd0;
      r_shift    <= 10'd0;
      r_tx       <= 1'b0;
      r_rd       <= 1'b0;
    end else if (enable) begin
      if (r_cnt == 4'd9) begin
        r_shift <= w_enc_code;
        r_tx    <= w_enc_code[0];
        r_cnt   <= 4'd0;
        r_rd    <= w_enc_disp;
        case (r_state)
          ST_SYNC: begin
            r_sync_cnt <= r_sync_cnt + 4'd1;
            if ((r_sync_cnt + 4'd1) == LP_SYNC) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_state <= ST_RUN;
          end
          default: begin
            r_state <= ST_SYNC;
          end
        endcase
      end else begin
        // Rotate so that the next bit to send is always at index 1.
        r_cnt   <= r_cnt + 4'd1;
        r_tx    <= r_shift[1];
        r_shift <= {r_shift[0], r_shift[9:1]};
      end
    end
  end

endmodule

// File: doc/serdes_tx.md
SERDES_TX -- requirements
Module: serdes_tx

Interface
REQ-001 SHALL have parameter SYNC_COMMAS, default 4, number of K28.5 symbols sent after reset before data is accepted (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  clock enable; low freezes all state, outputs hold.
REQ-005 SHALL have port data_in  input  9  symbol to send; [8]=K flag, [7:0]=HGFEDCBA.
REQ-006 SHALL have port data_valid  input  1  data_in holds a symbol to send.
REQ-007 SHALL have port data_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port tx_out  output  1  registered serial line output.
REQ-009 SHALL have port sync_done  output  1  high once the SYNC_COMMAS preamble has completed.
REQ-010 SHALL have port disp_out  output  1  running disparity after the symbol currently being sent (0=RD-, 1=RD+).

Function
REQ-011 SHALL instantiate the codebase's 8b/10b encoder (the encode module: datain[8:0], dispin, dataout[9:0]={j,h,g,f,i,e,d,c,b,a}, dispout) for all symbols.
REQ-012 SHALL keep a 4-bit bit counter 0..9; word boundary = counter==9 with enable high.
REQ-013 SHALL, at each word boundary, select a symbol, capture the encoder dataout into a 10-bit shift register, drive bit a on tx_out at that same edge, set counter to 0, and load running disparity from encoder dispout.
REQ-014 SHALL, on each non-boundary enabled edge, increment counter and drive the next bit in order a,b,c,d,e,i,f,g,h,j (dataout[0] first).
REQ-015 SHALL implement states SYNC and RUN; reset enters SYNC.
REQ-016 SHALL, in SYNC, select K28.5 (9'h1BC) at every boundary, ignore data_valid, and count symbols sent; after the SYNC_COMMAS-th comma is loaded, go to RUN at that edge.
REQ-017 SHALL assert sync_done exactly when state is RUN.
REQ-018 SHALL drive data_ready combinationally = enable AND state==RUN AND counter==9.
REQ-019 SHALL transfer data_in when data_valid AND data_ready; the transferred symbol is encoded and its bit a appears on tx_out immediately after that edge.
REQ-020 SHALL, in RUN at a boundary with data_valid low, send K28.5 as idle fill using current running disparity.
REQ-021 SHALL feed dispin of the encoder from the running-disparity register; disp_out equals that register.
REQ-022 SHALL not buffer data; data_valid with data_ready low has no effect and data_in is not sampled.
REQ-023 SHALL hold all registers and tx_out unchanged while enable is low, including mid-word; the word resumes at the next bit when enable returns.
REQ-024 SHALL pass K-flagged symbols to the encoder unmodified; invalid K codes are the encoder's responsibility.

Reset
REQ-025 SHALL, when reset is high at a clock edge, set tx_out=0, counter=9, running disparity=0, state=SYNC, sync comma count=0, shift register=0, regardless of enable or current bit position.
REQ-026 SHALL, during and after reset until the first enabled edge, present data_ready=0, sync_done=0, disp_out=0.
REQ-027 SHALL, on reset asserted mid-word, abandon the word; the first enabled edge after reset release starts a new K28.5 with RD-.

Verification
REQ-028 SHALL verify: reset, enable=1, SYNC_COMMAS=4 -> tx_out bits 0,0,1,1,1,1,1,0,1,0 then 1,1,0,0,0,0,0,1,0,1, alternating; sync_done rises at the 4th comma's load edge; data_ready first high 9 cycles later.
REQ-029 SHALL verify: after sync, data_in=9'h0B5 (D21.5) with data_valid held -> accepted on data_ready edge; tx_out 1,0,1,0,1,0,1,0,1,0; disp_out unchanged.
REQ-030 SHALL verify: RD- and data_in=9'h000 (D0.0) -> tx_out 1,0,0,1,1,1,0,1,0,0, disp_out stays 0; same symbol at RD+ -> 0,1,1,0,0,0,1,0,1,1.
REQ-031 SHALL verify: data_valid low in RUN -> K28.5 idle fill each word with correct alternation; data_valid raised mid-word -> data_ready only at counter==9, no symbol lost or duplicated.
REQ-032 SHALL verify: enable dropped for 5 cycles at bit 4 -> tx_out frozen, word completes with all 10 bits intact, timing shifted by 5 cycles.
REQ-033 SHALL verify: reset at bit 6 of a data word -> tx_out=0 next edge, then full SYNC_COMMAS preamble starting RD- before data_ready rises; loopback through serdes_rx yields identical data_out sequence, code_err=0, disp_err=0.
